// File: rtl/constants_pkg.sv
// Shared widths and instruction field encodings.
package constants_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 64;
  localparam int unsigned F3_W   = 3;

  // Load funct3 codes
  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

endpackage

// File: rtl/structure_pkg.sv
// Pipeline payload types and writeback FSM encoding.
package structure_pkg;
  import constants_pkg::*;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic [F3_W-1:0]   funct3;
    logic [XLEN-1:0]   alu_res;
    logic [XLEN-1:0]   mem_rdata;
    logic              reg_data_ready;
  } inst_decoded_t;

  typedef enum logic {
    RUN       = 1'b0,
    WAIT_DATA = 1'b1
  } wb_state_t;

endpackage

// File: rtl/load_formatter.sv
// Aligns a loaded word by byte offset and applies the funct3 width/extension.
module load_formatter
  import constants_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [F3_W-1:0] funct3,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;

  // Misaligned offsets simply truncate after the shift; no trap.
  always_comb begin
    shifted = word >> {offset, 3'b000};
    case (funct3)
      F3_LB:   result = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_LH:   result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LW:   result = shifted;
      F3_LBU:  result = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: retires the held instruction into the register file,
// stalling the memory stage while a missed load waits for its data.
module writeback_stage
  import constants_pkg::*;
  import structure_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  inst_decoded_t     inst_wb_in,
  output logic              stall_wb_out,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              bypass_valid,
  output logic [REG_AW-1:0] bypass_rd,
  output logic [XLEN-1:0]   bypass_data,
  output logic [CNT_W-1:0]  instret
);

  inst_decoded_t    held_q;
  wb_state_t        state_q;
  wb_state_t        state_d;
  logic [CNT_W-1:0] instret_q;

  logic             pending;
  logic             retire;
  logic             wr_en;
  logic [XLEN-1:0]  load_word;
  logic [XLEN-1:0]  load_data;
  logic [XLEN-1:0]  wr_data;

  assign pending = held_q.valid & held_q.mem_read & ~held_q.reg_data_ready;

  // Stage register: frozen while stalled so the memory stage can hold too.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) held_q <= '0;
    else if (!stall_wb_out) held_q <= inst_wb_in;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:       if (pending && !mem_rsp_valid) state_d = WAIT_DATA;
      WAIT_DATA: if (mem_rsp_valid) state_d = RUN;
      default:   state_d = RUN;
    endcase
  end

  // FSM outputs: a pending load retires only in the cycle its data arrives
  always_comb begin
    retire       = 1'b1;
    stall_wb_out = 1'b0;
    load_word    = held_q.mem_rdata;
    case (state_q)
      RUN: begin
        if (pending) begin
          load_word    = mem_rsp_data;
          retire       = mem_rsp_valid;
          stall_wb_out = ~mem_rsp_valid;
        end
      end
      WAIT_DATA: begin
        load_word    = mem_rsp_data;
        retire       = mem_rsp_valid;
        stall_wb_out = ~mem_rsp_valid;
      end
      default: ;
    endcase
  end

  load_formatter u_load_formatter (
    .word   (load_word),
    .offset (held_q.alu_res[1:0]),
    .funct3 (held_q.funct3),
    .result (load_data)
  );

  assign wr_data = held_q.mem_read ? load_data : held_q.alu_res;
  assign wr_en   = retire & held_q.valid & held_q.reg_write & (held_q.rd != '0);

  // Write port is zeroed when idle so reset and bubbles present a clean bus.
  assign rf_we        = wr_en;
  assign rf_waddr     = wr_en ? held_q.rd : '0;
  assign rf_wdata     = wr_en ? wr_data : '0;
  assign bypass_valid = rf_we;
  assign bypass_rd    = rf_waddr;
  assign bypass_data  = rf_wdata;

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) instret_q <= '0;
    else if (retire && held_q.valid) instret_q <= instret_q + CNT_W'(1);
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: a per-cycle reference model pushes
// expected port values, an independent monitor pops and compares them.
module tb_writeback_stage;
  import constants_pkg::*;
  import structure_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  inst_decoded_t inst_wb_in = '0;
  logic          stall_wb_out;
  logic          mem_rsp_valid = 1'b0;
  logic [31:0]   mem_rsp_data = '0;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic          bypass_valid;
  logic [4:0]    bypass_rd;
  logic [31:0]   bypass_data;
  logic [63:0]   instret;

  writeback_stage dut (
    .clk           (clk),
    .rst           (rst),
    .inst_wb_in    (inst_wb_in),
    .stall_wb_out  (stall_wb_out),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .bypass_valid  (bypass_valid),
    .bypass_rd     (bypass_rd),
    .bypass_data   (bypass_data),
    .instret       (instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [63:0] cnt;
  } exp_t;

  exp_t          exp_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;

  // Reference model state: the instruction sitting in the stage and the count
  inst_decoded_t cur = '0;
  logic [63:0]   count = '0;
  int            wait_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Load result from byte arithmetic on the aligned word
  function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] off,
                                      input logic [2:0] f3);
    logic [31:0] s, b, h;
    s = w >> (8 * int'(off));
    b = s & 32'h0000_00FF;
    h = s & 32'h0000_FFFF;
    case (f3)
      3'b000:  return (b >= 32'h80)   ? b - 32'h100     : b;
      3'b001:  return (h >= 32'h8000) ? h - 32'h1_0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return s;
    endcase
  endfunction

  function automatic inst_decoded_t rand_inst();
    inst_decoded_t i;
    i.valid          = ($urandom_range(0, 7) != 0);
    i.rd             = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
    i.reg_write      = ($urandom_range(0, 3) != 0);
    i.mem_read       = 1'($urandom_range(0, 1));
    i.funct3         = 3'($urandom_range(0, 7));
    i.alu_res        = $urandom;
    i.mem_rdata      = $urandom;
    i.reg_data_ready = ($urandom_range(0, 2) != 0);
    return i;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e = '0;
    return e;
  endfunction

  // One clock of stimulus. rsp_mode: 0 random, 1 no response, 2 response.
  task automatic cycle(input inst_decoded_t nxt, input int rsp_mode, input logic [31:0] rsp_word);
    logic pend, rsp, stall, we;
    logic [31:0] data;
    exp_t e;
    @(negedge clk);
    pend = cur.valid & cur.mem_read & ~cur.reg_data_ready;
    case (rsp_mode)
      1:       rsp = 1'b0;
      2:       rsp = 1'b1;
      default: rsp = pend ? (($urandom_range(0, 2) == 0) || (wait_cnt >= 5))
                          : 1'($urandom_range(0, 1));
    endcase
    mem_rsp_valid = rsp;
    mem_rsp_data  = rsp_word;
    stall = pend & ~rsp;
    we    = ~stall & cur.valid & cur.reg_write & (cur.rd != 5'd0);
    data  = !cur.mem_read ? cur.alu_res
                          : fmt(pend ? rsp_word : cur.mem_rdata, cur.alu_res[1:0], cur.funct3);
    e.stall = stall;
    e.we    = we;
    e.waddr = we ? cur.rd : 5'd0;
    e.wdata = we ? data : 32'd0;
    e.cnt   = count;
    exp_q.push_back(e);
    if (!stall && cur.valid) count = count + 64'd1;
    if (stall) wait_cnt++;
    else begin
      wait_cnt   = 0;
      cur        = nxt;
      inst_wb_in = nxt;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b0;
    inst_wb_in = '0;
    mem_rsp_valid = 1'b0;
    cur = '0;
    count = '0;
    wait_cnt = 0;
    exp_q.push_back(zero_exp());
    repeat (n) begin
      @(negedge clk);
      mem_rsp_valid = 1'($urandom_range(0, 1));
      exp_q.push_back(zero_exp());
    end
    @(negedge clk);
    rst = 1'b1;
    mem_rsp_valid = 1'b0;
    exp_q.push_back(zero_exp());
  endtask

  // Monitor: compares DUT ports against the oldest expected record
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("stall_wb_out", 64'(stall_wb_out), 64'(e.stall));
        chk("rf_we",        64'(rf_we),        64'(e.we));
        chk("rf_waddr",     64'(rf_waddr),     64'(e.waddr));
        chk("rf_wdata",     64'(rf_wdata),     64'(e.wdata));
        chk("bypass_valid", 64'(bypass_valid), 64'(e.we));
        chk("bypass_rd",    64'(bypass_rd),    64'(e.waddr));
        chk("bypass_data",  64'(bypass_data),  64'(e.wdata));
        chk("instret",      instret,           e.cnt);
      end
    end
  end

  initial begin : driver
    inst_decoded_t bub, add5, lb, lhu, miss, add0, filler;
    bub = '0;
    add5 = '0; add5.valid = 1'b1; add5.rd = 5'd5; add5.reg_write = 1'b1; add5.alu_res = 32'h1234;
    lb = '0; lb.valid = 1'b1; lb.rd = 5'd7; lb.reg_write = 1'b1; lb.mem_read = 1'b1;
    lb.funct3 = F3_LB; lb.alu_res = 32'h3; lb.mem_rdata = 32'h80FF_7F01; lb.reg_data_ready = 1'b1;
    lhu = lb; lhu.rd = 5'd8; lhu.funct3 = F3_LHU; lhu.alu_res = 32'h2;
    miss = '0; miss.valid = 1'b1; miss.rd = 5'd9; miss.reg_write = 1'b1; miss.mem_read = 1'b1;
    miss.funct3 = F3_LW; miss.mem_rdata = 32'h1111_2222;
    add0 = add5; add0.rd = 5'd0;
    filler = add5; filler.rd = 5'd12; filler.alu_res = 32'h5555;

    do_reset(3);

    // ALU writeback with bypass mirror and first count
    cycle(add5, 1, 32'h0);
    cycle(bub, 1, 32'h0);
    cycle(bub, 1, 32'h0);

    // Byte load at offset 3 and halfword load at offset 2
    cycle(lb, 1, 32'h0);
    cycle(lhu, 1, 32'h0);
    cycle(bub, 1, 32'h0);

    // Miss: three stalled cycles, then late data
    cycle(miss, 1, 32'h0);
    repeat (3) cycle(filler, 1, 32'h0);
    cycle(bub, 2, 32'hDEAD_BEEF);
    cycle(bub, 1, 32'h0);

    // rd=0 retires without writing, then a bubble
    cycle(add0, 1, 32'h0);
    cycle(bub, 1, 32'h0);
    cycle(bub, 1, 32'h0);

    // Reset while waiting on load data, then a stray response
    cycle(miss, 1, 32'h0);
    cycle(filler, 1, 32'h0);
    cycle(filler, 1, 32'h0);
    do_reset(2);
    cycle(bub, 2, 32'hCAFE_F00D);
    cycle(bub, 1, 32'h0);

    // Counter wrap from all ones
    @(posedge clk);
    #1;
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    count = 64'hFFFF_FFFF_FFFF_FFFF;
    cycle(add5, 1, 32'h0);
    release dut.instret_q;
    cycle(bub, 1, 32'h0);
    cycle(bub, 1, 32'h0);

    // Randomized traffic with one reset in the middle
    repeat (400) cycle(rand_inst(), 0, $urandom);
    do_reset(1);
    repeat (400) cycle(rand_inst(), 0, $urandom);
    cycle(bub, 2, $urandom);
    cycle(bub, 1, 32'h0);

    @(negedge clk);
    #3;
    chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, asynchronous assert, active-low.
REQ-004 inst_wb_in  input  inst_decoded_t  instruction from memory stage output.
REQ-005 stall_wb_out  output  1  back-pressure to memory stage; high holds inst_wb_in.
REQ-006 mem_rsp_valid  input  1  late load data present this cycle, after a cache miss.
REQ-007 mem_rsp_data  input  32  raw 32-bit word for the pending load.
REQ-008 rf_we / rf_waddr / rf_wdata  output  1/5/32  register-file write port.
REQ-009 bypass_valid / bypass_rd / bypass_data  output  1/5/32  forwarding to decode; mirror the register-file write port in the same cycle.
REQ-010 instret  output  64  retired-instruction count.
REQ-011 Consumed inst_decoded_t fields: valid, rd, reg_write, mem_read, funct3, alu_res[31:0], mem_rdata[31:0], reg_data_ready.

Function
REQ-012 The stage register SHALL capture inst_wb_in on each rising edge where stall_wb_out=0, and hold otherwise.
REQ-013 FSM states SHALL be RUN and WAIT_DATA.
REQ-014 "Pending" SHALL mean held.valid & held.mem_read & ~held.reg_data_ready.
REQ-015 RUN, not pending: the held instruction retires combinationally in the same cycle; stall_wb_out=0.
REQ-016 RUN, pending, mem_rsp_valid=0: stall_wb_out=1, no write, next state WAIT_DATA.
REQ-017 WAIT_DATA, or RUN while pending, with mem_rsp_valid=1: retire using mem_rsp_data; stall_wb_out=0; next state RUN.
REQ-018 WAIT_DATA with mem_rsp_valid=0: stall_wb_out=1, no write, remain in WAIT_DATA.
REQ-019 Write data source: alu_res if ~mem_read; formatted load data if mem_read (mem_rdata, or mem_rsp_data on the late path).
REQ-020 Load formatting: shift the word right by 8*alu_res[1:0], then extend.
  - funct3 000 LB: sign-extend byte
  - 001 LH: sign-extend half
  - 010 LW: full word
  - 100 LBU: zero-extend byte
  - 101 LHU: zero-extend half
  - other codes: full word
REQ-021 Misaligned offsets SHALL not trap; the shift-and-truncate result is used.
REQ-022 rf_we SHALL be asserted only on a retiring cycle with held.valid & held.reg_write & rd≠0.
REQ-023 rd=0 SHALL retire with rf_we=0 and bypass_valid=0.
REQ-024 instret SHALL increment by 1 on every retiring cycle with held.valid=1, including rd=0 and non-writing instructions.
REQ-025 instret SHALL wrap modulo 2^64.
REQ-026 A bubble (held.valid=0) SHALL cause no write and no count, and SHALL never stall.
REQ-027 mem_rsp_valid while not pending SHALL be ignored.

Reset
REQ-028 While rst=0, all of the following SHALL hold:
  - state=RUN
  - held.valid=0
  - instret=0
  - rf_we=0, bypass_valid=0, stall_wb_out=0
  - rf_waddr=0, rf_wdata=0, bypass_rd=0, bypass_data=0
REQ-029 Reset asserted during WAIT_DATA SHALL abandon the pending load with no write; on release the FSM SHALL be in RUN with an empty stage.

Structure
REQ-030 A wb_state_t enum SHALL be added to structure_pkg.
REQ-031 Load funct3 codes (LB, LH, LW, LBU, LHU) SHALL be added to constants_pkg.
REQ-032 Load formatting SHALL be a combinational sub-module named load_formatter (inputs: word, offset, funct3; output: 32-bit result).

Verification
REQ-033 ADD: rd=5, alu_res=0x1234, valid=1 -> next cycle rf_we=1, waddr=5, wdata=0x1234, bypass mirrors, instret 0->1.
REQ-034 LB: mem_rdata=0x80FF7F01, alu_res[1:0]=3, reg_data_ready=1 -> wdata=0xFFFFFF80. LHU offset 2 -> 0x000080FF.
REQ-035 Miss: load with reg_data_ready=0 -> stall_wb_out=1 for 3 cycles. Then mem_rsp_valid=1, data=0xDEADBEEF, LW -> wdata=0xDEADBEEF in that cycle, stall low, inst_wb_in held stable throughout.
REQ-036 rd=0 ADD, then a bubble -> no rf_we either cycle; instret +1 only for the ADD.
REQ-037 Reset during WAIT_DATA, then mem_rsp_valid=1 after release -> no write, instret=0, stall_wb_out=0.
REQ-038 Preload instret=0xFFFF_FFFF_FFFF_FFFF (via force), retire one instruction -> instret=0.
